// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage : instruction-fetch stage, first stage of the pipeline.
//
// Owns the program counter, issues reads to a synchronous-read program memory
// (one cycle of read latency) and hands instructions to decode through the
// IF/ID register. A one-entry skid buffer absorbs a response that returns
// while decode is stalled. Execute can redirect fetch, and fetching an
// instruction whose top three bits are 3'b111 (HALT) stops fetch until reset.
//
// Optional feature macro: FETCH_STATS_EN (adds fetch_count / stall_count).
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   mem_rd       read strobe to program memory
//   mem_addr     read address (equals pc when mem_rd=1)
//   mem_rdata    read data, valid the cycle after mem_rd
//   stall        decode cannot accept; hold IF/ID
//   redirect     taken branch from execute
//   redirect_pc  branch target
//   pc           current fetch PC
//   if_id_valid  IF/ID holds a live instruction
//   if_id_instr  fetched instruction
//   if_id_pc     address of if_id_instr
//   fetch_halted HALT fetched; fetch stopped
//   fetch_count  (FETCH_STATS_EN) instructions loaded into IF/ID, saturating
//   stall_count  (FETCH_STATS_EN) cycles with stall=1 and if_id_valid=1, saturating
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int PC_W     = 9,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               mem_rd,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    pc,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic               fetch_halted
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]        fetch_count,
  output logic [15:0]        stall_count
`endif
);

  typedef enum logic [1:0] {ST_RST, ST_FETCH, ST_HALTED} state_t;

  state_t               state;
  logic                 pending;     // a read was issued last cycle; data is on mem_rdata now
  logic [PC_W-1:0]      req_pc;      // address of the pending read
  logic                 skid_valid;
  logic [INSTR_W-1:0]   skid_instr;
  logic [PC_W-1:0]      skid_pc;

  logic                 hold;
  logic                 issue;
  logic                 load_en;
  logic [INSTR_W-1:0]   load_instr;
  logic [PC_W-1:0]      load_pc;
  logic                 halt_load;

  // IF/ID only really holds when it has something live; an empty IF/ID may be
  // refilled even while decode is asserting stall.
  assign hold = stall && if_id_valid;

  // Issue is blocked while a stalled response would have nowhere to go
  // (skid full, or a response about to land in it).
  assign issue    = (state == ST_FETCH) && !redirect && !(hold && (pending || skid_valid));
  assign mem_rd   = issue;
  assign mem_addr = pc;

  // Select what IF/ID loads this cycle: the skid buffer is older than any
  // response returning now, so it drains first.
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    load_en    = 1'b0;
    load_instr = skid_instr;
    load_pc    = skid_pc;
    if (state == ST_FETCH && !redirect && !hold) begin
      if (skid_valid) begin
        load_en = 1'b1;
      end else if (pending) begin
        load_en    = 1'b1;
        load_instr = mem_rdata;
        load_pc    = req_pc;
      end
    end
  end

  assign halt_load = load_en && (load_instr[INSTR_W-1 -: 3] == 3'b111);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  // NOTE: the skid buffer and IF/ID data are plain registers, not a memory
  // array, so resetting them is cheap and keeps outputs deterministic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_RST;
      pc           <= PC_W'(RESET_PC);
      req_pc       <= '0;
      pending      <= 1'b0;
      skid_valid   <= 1'b0;
      skid_instr   <= '0;
      skid_pc      <= '0;
      if_id_valid  <= 1'b0;
      if_id_instr  <= '0;
      if_id_pc     <= '0;
      fetch_halted <= 1'b0;
    end else begin
      case (state)
        ST_RST: begin
          state <= ST_FETCH;
        end

        ST_FETCH: begin
          if (redirect) begin
            // Squash everything younger than the branch.
            pc          <= redirect_pc;
            pending     <= 1'b0;
            skid_valid  <= 1'b0;
            if_id_valid <= 1'b0;
          end else begin
            if (issue) begin
              req_pc <= pc;
              pc     <= pc + PC_W'(1);
            end
            pending <= issue;

            if (hold) begin
              if (pending) begin
                skid_instr <= mem_rdata;
                skid_pc    <= req_pc;
                skid_valid <= 1'b1;
              end
            end else begin
              if_id_valid <= load_en;
              if (load_en) begin
                if_id_instr <= load_instr;
                if_id_pc    <= load_pc;
              end
              if (skid_valid) begin
                if (pending) begin
                  // Skid drained into IF/ID; the new response takes its place.
                  skid_instr <= mem_rdata;
                  skid_pc    <= req_pc;
                end else begin
                  skid_valid <= 1'b0;
                end
              end
            end

            if (halt_load) begin
              // HALT goes downstream; anything fetched after it is dropped.
              state        <= ST_HALTED;
              fetch_halted <= 1'b1;
              pending      <= 1'b0;
              skid_valid   <= 1'b0;
            end
          end
        end

        ST_HALTED: begin
          if (!stall) if_id_valid <= 1'b0;
        end

        default: state <= ST_RST;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (load_en && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
      if (stall && if_id_valid && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule
